fetch_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage: owns the PC, reads instruction memory, buffers

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/fetch_prefetch_unit.sv | 86 ++++++++
 tb/tb_fetch_prefetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage constants, entry layout and field helpers
package fetch_pkg;

    localparam int         DEF_PC_W    = 8;
    localparam int         DEF_INSTR_W = 32;
    localparam int         DEF_OP_W    = 4;
    localparam logic [3:0] DEF_HALT_OP = 4'b0000;
    localparam int         DEF_ENTRY_W = DEF_PC_W + DEF_INSTR_W;

    // Queue entry as seen by decode at the default widths: pc in the upper bits
    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Width of one {pc, instr} queue entry
    function automatic int entry_width(input int pc_w, input int instr_w);
        return pc_w + instr_w;
    endfunction

    // Bit position of the opcode field's LSB; the opcode sits in the top OP_W bits
    function automatic int opcode_lsb(input int instr_w, input int op_w);
        return instr_w - op_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - DEPTH-entry synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap at DEPTH explicitly so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage write; the caller only pushes when a slot is free or freed this edge
    always_ff @(posedge clock) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero while empty so stale storage never leaks out
    assign o_rdata = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - PC owner, imem fetch and prefetch queue front end
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int             PC_W     = DEF_PC_W,
    parameter int             INSTR_W  = DEF_INSTR_W,
    parameter int             DEPTH    = 4,
    parameter int             RESET_PC = 0,
    parameter int             OP_W     = DEF_OP_W,
    parameter int             HALT_EN  = 1,
    parameter logic [OP_W-1:0] HALT_OP = OP_W'(DEF_HALT_OP)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               halted
);

    localparam int ENTRY_W = entry_width(PC_W, INSTR_W);
    localparam int OP_LSB  = opcode_lsb(INSTR_W, OP_W);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    r_pc;
    logic               r_halted;

    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_is_halt_op;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;

    assign out_valid    = (w_count != '0);
    assign w_full       = (w_count == CNT_W'(DEPTH));
    assign w_pop        = out_valid & out_ready;
    // A full queue still fetches when decode frees the head slot on the same edge
    assign w_push       = !redirect_valid & !r_halted & (!w_full | w_pop);
    assign w_is_halt_op = (imem_rdata[OP_LSB +: OP_W] == HALT_OP);
    assign w_wdata      = {r_pc, imem_rdata};

    assign imem_en      = w_push;
    assign imem_addr    = r_pc;
    assign out_pc       = w_rdata[ENTRY_W-1 -: PC_W];
    assign out_instr    = w_rdata[INSTR_W-1:0];
    assign halted       = r_halted;

    // PC and halt flag: redirect restarts fetch anywhere and clears a halt
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= PC_W'(RESET_PC);
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
        end else if (w_push) begin
            r_pc <= r_pc + PC_W'(1);
            if ((HALT_EN != 0) && w_is_halt_op) begin
                r_halted <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

    localparam int         PC_W    = 6;
    localparam int         INSTR_W = 16;
    localparam int         DEPTH   = 3;
    localparam int         NWORDS  = 1 << PC_W;
    localparam logic [3:0] HOP     = 4'hF;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               redirect_valid = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               halted;

    logic [INSTR_W-1:0] mem [NWORDS];

    int checks = 0;
    int errors = 0;

    logic [PC_W+INSTR_W-1:0] m_q [$];
    int                      m_pc;
    bit                      m_halt;

    always #5 clock = ~clock;

    assign imem_rdata = mem[imem_addr];

    fetch_prefetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0),
        .OP_W     (4),
        .HALT_EN  (1),
        .HALT_OP  (HOP)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already driven: check, advance model, one cycle
    task automatic step();
        bit pop;
        bit push;
        #1;
        pop  = (m_q.size() > 0) && out_ready;
        push = !redirect_valid && !m_halt && ((m_q.size() < DEPTH) || pop);
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check_eq("out_pc", 32'(out_pc), 32'(m_q[0][PC_W+INSTR_W-1 -: PC_W]));
            check_eq("out_instr", 32'(out_instr), 32'(m_q[0][INSTR_W-1:0]));
        end
        check_eq("imem_en", 32'(imem_en), 32'(push));
        check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
        check_eq("halted", 32'(halted), 32'(m_halt));
        if (redirect_valid) begin
            m_q.delete();
            m_pc   = int'(redirect_pc);
            m_halt = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({PC_W'(m_pc), mem[m_pc]});
                if (mem[m_pc][INSTR_W-1 -: 4] == HOP) m_halt = 1'b1;
                m_pc = (m_pc + 1) % NWORDS;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Asserts reset at the current time, checks outputs before any clock edge, releases at a falling edge
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pc", 32'(out_pc), 32'd0);
        check_eq("rst_out_instr", 32'(out_instr), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
        m_q.delete();
        m_pc   = 0;
        m_halt = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = INSTR_W'(i + 1);
        @(negedge clock);
        do_reset();

        // streaming with decode always ready
        out_ready = 1'b1;
        repeat (6) step();

        // backpressure fills the queue, then drains with no gap
        out_ready = 1'b0;
        repeat (6) step();
        out_ready = 1'b1;
        repeat (8) step();

        // redirect while the queue is full
        out_ready = 1'b0;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 6'h20;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (5) step();

        // redirect in the same cycle as a pop
        redirect_valid = 1'b1;
        redirect_pc    = 6'h10;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();

        // full queue with pop and push on the same edge
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        repeat (4) step();

        // halt opcode at address 3, then redirect to 0 clears it
        mem[3] = 16'hF003;
        do_reset();
        out_ready = 1'b1;
        repeat (10) step();
        redirect_valid = 1'b1;
        redirect_pc    = '0;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();
        mem[3] = 16'h0004;

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 6'h3E;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();

        // asynchronous reset mid-cycle with entries queued
        out_ready = 1'b0;
        repeat (4) step();
        #2;
        do_reset();
        out_ready = 1'b1;
        repeat (4) step();

        // randomized traffic, halts arise naturally from random opcodes
        for (int i = 0; i < NWORDS; i++) mem[i] = INSTR_W'($urandom);
        for (int n = 0; n < 3000; n++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = PC_W'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                redirect_valid = 1'b0;
                #2;
                do_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
